// File: rtl/div_seq.sv
// Sequential restoring divider: one shared WIDTH+1-bit subtractor stepped once per clock.
// Define DIV_SIGNED_EN for two's-complement operands (adds one sign-correction cycle).
module div_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StZero,
    StSign,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend, shifted out as quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] pr_q, pr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef DIV_SIGNED_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
`endif

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] pr_step;
  logic [WIDTH-1:0] dvd_step;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  always_comb begin
    shifted  = {pr_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    q_bit    = ~diff[WIDTH];
    pr_step  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_step = {dvd_q[WIDTH-2:0], q_bit};
  end

`ifdef DIV_SIGNED_EN
  always_comb begin
    mag1 = in1[WIDTH-1] ? (-in1) : in1;
    mag2 = in2[WIDTH-1] ? (-in2) : in2;
  end
`else
  always_comb begin
    mag1 = in1;
    mag2 = in2;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    out_d   = out_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          dbz_d = 1'b0;
          if (in2 == '0) begin
            // Raw dividend is parked in dvd_q so it can be reported as the remainder.
            dvd_d   = in1;
            state_d = StZero;
          end else begin
            dvd_d   = mag1;
            dvs_d   = mag2;
            pr_d    = '0;
            cnt_d   = CntInit;
            state_d = StRun;
`ifdef DIV_SIGNED_EN
            qneg_d  = in1[WIDTH-1] ^ in2[WIDTH-1];
            rneg_d  = in1[WIDTH-1];
`endif
          end
        end else begin
          state_d = StIdle;
        end
      end
      StZero: begin
        out_d   = '1;
        rem_d   = dvd_q;
        dbz_d   = 1'b1;
        state_d = StDone;
      end
      StRun: begin
        pr_d  = pr_step;
        dvd_d = dvd_step;
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
`ifdef DIV_SIGNED_EN
          state_d = StSign;
`else
          out_d   = dvd_step;
          rem_d   = pr_step;
          state_d = StDone;
`endif
        end
      end
      StSign: begin
`ifdef DIV_SIGNED_EN
        out_d = qneg_q ? (-dvd_q) : dvd_q;
        rem_d = rneg_q ? (-pr_q) : pr_q;
`endif
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun) || (state_d == StSign);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign out         = out_q;
  assign rem         = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus queues expected results, a monitor checks each done.
module tb_div_seq;

`ifdef DIV_SIGNED_EN
  localparam int Lat = 17;
`else
  localparam int Lat = 16;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [15:0] out;
  logic [15:0] rem;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  div_seq #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in1        (in1),
    .in2        (in2),
    .out        (out),
    .rem        (rem),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", {16'h0, out}, {16'h0, e.q});
        check("remainder", {16'h0, rem}, {16'h0, e.r});
        check("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.z});
        check("done_cycle", cyc, e.t);
      end
    end
  end

  // Caller is at a negedge; the following posedge is the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                       input logic [15:0] r, input logic z, input int lat, input bit push);
    exp_t e;
    start = 1'b1;
    in1   = a;
    in2   = b;
    if (push) begin
      e.q = q;
      e.r = r;
      e.z = z;
      e.t = cyc + 1 + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    in1   = 16'($urandom);
    in2   = 16'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || busy || done) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", {31'h0, k >= 200}, 32'h0);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", {31'h0, k >= 200}, 32'h0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out"}, {16'h0, out}, 32'h0);
    check({tag, "_rem"}, {16'h0, rem}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_dbz"}, {31'h0, div_by_zero}, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;

    @(negedge clk);
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, Lat, 1'b1);
    wait_idle();

    @(negedge clk);
    issue(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, Lat, 1'b1);
    wait_idle();
    @(negedge clk);
    issue(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, Lat, 1'b1);
    wait_idle();

    // Divide by zero: one-cycle turnaround, busy never asserted.
    @(negedge clk);
    issue(16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1'b1, 1, 1'b1);
    repeat (3) begin
      check("dbz_busy", {31'h0, busy}, 32'h0);
      @(negedge clk);
    end
    wait_idle();

    // Start mid-run is ignored; then a back-to-back start in the DONE cycle.
    @(negedge clk);
    issue(16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, Lat, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    in1   = 16'd7;
    in2   = 16'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(16'd300, 16'd17, 16'd17, 16'd11, 1'b0, Lat, 1'b1);
    check("b2b_busy", {31'h0, busy}, 32'h1);
    wait_idle();

    // Reset mid-run aborts without a done pulse.
    @(negedge clk);
    issue(16'd1000, 16'd3, 16'd0, 16'd0, 1'b0, Lat, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("abort");
    repeat (25) @(negedge clk);
    issue(16'd60, 16'd6, 16'd10, 16'd0, 1'b0, Lat, 1'b1);
    wait_idle();

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    in1   = 16'd9;
    in2   = 16'd3;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("reset_wins_busy", {31'h0, busy}, 32'h0);
    repeat (20) @(negedge clk);

`ifdef DIV_SIGNED_EN
    @(negedge clk);
    issue(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, Lat, 1'b1);
    wait_idle();
    @(negedge clk);
    issue(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, Lat, 1'b1);
    wait_idle();
`else
    @(negedge clk);
    issue(16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, Lat, 1'b1);
    wait_idle();
    @(negedge clk);
    issue(16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFE, 1'b0, Lat, 1'b1);
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential 16-bit integer divider: the inverse of the datapath adder, built from one shared subtractor stepped once per clock (restoring algorithm). Sits beside `add` in the ALU as a multi-cycle unit, started by a one-cycle `start` pulse and reporting completion with `done`. Quotient on `out`; operands on `in1` (dividend) and `in2` (divisor), matching the adder's port naming.

## Interface
- `WIDTH`, 16, operand/result width in bits.
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request; sampled only in IDLE or DONE.
- `in1` input WIDTH: dividend; sampled on the accepting edge only.
- `in2` input WIDTH: divisor; sampled on the accepting edge only.
- `out` output WIDTH: quotient.
- `rem` output WIDTH: remainder.
- `busy` output 1: high while dividing.
- `done` output 1: one-cycle pulse; results valid.
- `div_by_zero` output 1: set with `done` when `in2` was 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `start`=1:
  - `in2`≠0: latch operands, step counter=WIDTH, partial remainder=0, go RUN.
  - `in2`=0: go DONE, `out`=all ones, `rem`=`in1`, `div_by_zero`=1.
- RUN, each cycle:
  - shift {partial remainder, dividend} left one bit.
  - Trial subtract divisor with a WIDTH+1-bit subtractor.
  - Non-negative: keep the difference, shift quotient bit 1. Negative: restore, shift quotient bit 0.
  - Decrement counter. At 0, go DONE and load `out`/`rem`.
- DONE:
  - `done`=1 for exactly this one cycle.
  - `start`=1: accepted as from IDLE (back-to-back). Otherwise go IDLE.
- `out`, `rem`, `div_by_zero` hold until the next accepted `start` or `reset`. `div_by_zero` clears on the next accepted `start`.
- `start` in RUN is ignored: no queueing, operands unchanged.
- Input changes outside the accepting edge have no effect.
- `reset` in any state, including mid-RUN: abort, go IDLE next edge, no `done` pulse.

## Timing
- Reset values: `out`=0, `rem`=0, `busy`=0, `done`=0, `div_by_zero`=0, state IDLE.
- Accepting edge E0. Normal divide: `busy`=1 after E0 through E(WIDTH−1); `done`=1 after E(WIDTH) for one cycle. Latency WIDTH cycles (16 by default).
- Divide-by-zero: `done`=1 after E0+1; `busy` stays 0.
- Back-to-back: `start` in the DONE cycle gives `busy`=1 the cycle after `done`. No idle gap.
- Simultaneous `reset` and `start`: `reset` wins.
- All outputs registered. No combinational path from inputs to outputs.

## Configuration
- `DIV_SIGNED_EN` defined: two's-complement operands.
  - Divide magnitudes; quotient negated when signs differ; remainder takes dividend's sign.
  - 0x8000 / 0xFFFF gives `out`=0x8000 (wraps), `rem`=0. No flag.
  - Divide-by-zero behaviour unchanged.
  - Adds one cycle of latency for the sign-correction step.
- Undefined: unsigned only, latency WIDTH.

## Test plan
- Reset then `start` with `in1`=100, `in2`=7 → `done` exactly 16 cycles after the accepting edge; `out`=14, `rem`=2, `div_by_zero`=0.
- `in1`=0xFFFF, `in2`=1 → `out`=0xFFFF, `rem`=0. Then `in1`=5, `in2`=9 → `out`=0, `rem`=5.
- `in2`=0, `in1`=0x1234 → `done` one cycle after accept; `out`=0xFFFF, `rem`=0x1234, `div_by_zero`=1, `busy` never high.
- Pulse `start` with new operands at RUN cycle 5 → ignored; original result delivered at cycle 16. Then `start` in the DONE cycle → second divide completes 16 cycles later.
- `reset` at RUN cycle 8 → no `done`; all outputs 0 next cycle. Fresh `start` then works normally.
- With `DIV_SIGNED_EN`: −7/2 → `out`=0xFFFD, `rem`=0xFFFF, `done` 17 cycles after the accepting edge. 0x8000/0xFFFF → `out`=0x8000, `rem`=0.
